osecpu_dr_capture: RTL and testbench

//  Parametrised successor to the single CPDR debug register in the OSECPU top level.

---
 rtl/osecpu_dr_capture.sv | 149 ++++++++++++++
 tb/tb_osecpu_dr_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/osecpu_dr_capture.sv
// osecpu_dr_capture
//   Captures CPDR debug write-backs. Each accepted capture updates a per-channel
//   "latest value" register and is queued, tagged with its channel, in a
//   first-word fall-through FIFO that a host or UART bridge drains.
// Ports
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   cap_valid/ch/data     : capture strobe, target channel, value
//   clr                   : synchronous flush of FIFO, ovf_cnt and bad_ch
//   dr_flat               : latest value per channel, channel k at [k*DW +: DW]
//   stall                 : MODE 2 only, FIFO full (hold CPDR)
//   out_valid/ready/ch/data : FIFO head handshake and contents
//   count                 : FIFO occupancy
//   ovf_cnt               : saturating count of lost or overwritten captures
//   bad_ch                : sticky, a capture named a channel >= NCH
module osecpu_dr_capture #(
   parameter int unsigned DW    = 32,
   parameter int unsigned NCH   = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned MODE  = 0,
   localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cap_valid,
   input  logic [CHW-1:0]    cap_ch,
   input  logic [DW-1:0]     cap_data,
   input  logic              clr,
   output logic [NCH*DW-1:0] dr_flat,
   output logic              stall,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CHW-1:0]    out_ch,
   output logic [DW-1:0]     out_data,
   output logic [CW-1:0]     count,
   output logic [15:0]       ovf_cnt,
   output logic              bad_ch
);

   localparam int unsigned    AW      = $clog2(DEPTH);
   localparam logic [CHW:0]   NchLim  = (CHW + 1)'(NCH);
   localparam logic [CW-1:0]  FullCnt = CW'(DEPTH);

   logic [DW-1:0]     dr_q [NCH];
   logic [DW-1:0]     dr_d [NCH];
   logic [CHW+DW-1:0] mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [15:0]       ovf_q, ovf_d;
   logic              bad_q, bad_d;
   logic              accept, full, pop, mem_we;
   logic [CHW+DW-1:0] head;

   assign accept    = cap_valid && ({1'b0, cap_ch} < NchLim);
   assign full      = (count_q == FullCnt);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign stall     = (MODE == 2) ? full : 1'b0;

   assign head      = mem_q[rd_ptr_q];
   assign out_ch    = head[CHW+DW-1:DW];
   assign out_data  = head[DW-1:0];
   assign count     = count_q;
   assign ovf_cnt   = ovf_q;
   assign bad_ch    = bad_q;

   for (genvar k = 0; k < NCH; k++) begin : g_flat
      assign dr_flat[k*DW +: DW] = dr_q[k];
   end

   // Latest-value registers ignore clr and FIFO state.
   always_comb begin
      dr_d = dr_q;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (accept && (cap_ch == CHW'(k))) begin
            dr_d[k] = cap_data;
         end
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      bad_d    = bad_q;
      mem_we   = 1'b0;
      if (clr) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = '0;
         bad_d    = 1'b0;
      end else begin
         if (cap_valid && !accept) begin
            bad_d = 1'b1;
         end
         if (accept && (!full || pop)) begin
            // Room available, or a same-cycle pop frees the slot.
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
               count_d = count_q + CW'(1);
            end
         end else if (accept) begin
            // Full with no pop: the capture is lost, or displaces the oldest.
            ovf_d = (ovf_q == 16'hFFFF) ? ovf_q : ovf_q + 16'd1;
            if (MODE == 1) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               rd_ptr_d = rd_ptr_q + AW'(1);
            end
         end else if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NCH; k++) begin
            dr_q[k] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= '0;
         bad_q    <= 1'b0;
      end else begin
         dr_q     <= dr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         bad_q    <= bad_d;
      end
   end

   // Storage needs no reset; contents are only observed while out_valid.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= {cap_ch, cap_data};
      end
   end

endmodule

// File: tb/tb_osecpu_dr_capture.sv
// Bench for osecpu_dr_capture: four instances (MODE 0/1/2 with NCH=4, and
// MODE 0 with NCH=3) share one set of inputs; each phase checks the relevant ones.
module tb_osecpu_dr_capture;

   logic        clk;
   logic        rst_n;
   logic        cap_valid;
   logic [1:0]  cap_ch;
   logic [31:0] cap_data;
   logic        clr;
   logic        out_ready;

   logic [127:0] dr0, dr1, dr2;
   logic [95:0]  dr3;
   logic         st0, st1, st2, st3;
   logic         ov0, ov1, ov2, ov3;
   logic [1:0]   oc0, oc1, oc2, oc3;
   logic [31:0]  od0, od1, od2, od3;
   logic [3:0]   cn0, cn1, cn2, cn3;
   logic [15:0]  of0, of1, of2, of3;
   logic         bd0, bd1, bd2, bd3;

   int n_cmp = 0;
   int n_bad = 0;

   osecpu_dr_capture #(.DW(32), .NCH(4), .DEPTH(8), .MODE(0)) u_m0 (
      .clk(clk), .reset(rst_n), .cap_valid(cap_valid), .cap_ch(cap_ch), .cap_data(cap_data),
      .clr(clr), .dr_flat(dr0), .stall(st0), .out_valid(ov0), .out_ready(out_ready),
      .out_ch(oc0), .out_data(od0), .count(cn0), .ovf_cnt(of0), .bad_ch(bd0));
   osecpu_dr_capture #(.DW(32), .NCH(4), .DEPTH(8), .MODE(1)) u_m1 (
      .clk(clk), .reset(rst_n), .cap_valid(cap_valid), .cap_ch(cap_ch), .cap_data(cap_data),
      .clr(clr), .dr_flat(dr1), .stall(st1), .out_valid(ov1), .out_ready(out_ready),
      .out_ch(oc1), .out_data(od1), .count(cn1), .ovf_cnt(of1), .bad_ch(bd1));
   osecpu_dr_capture #(.DW(32), .NCH(4), .DEPTH(8), .MODE(2)) u_m2 (
      .clk(clk), .reset(rst_n), .cap_valid(cap_valid), .cap_ch(cap_ch), .cap_data(cap_data),
      .clr(clr), .dr_flat(dr2), .stall(st2), .out_valid(ov2), .out_ready(out_ready),
      .out_ch(oc2), .out_data(od2), .count(cn2), .ovf_cnt(of2), .bad_ch(bd2));
   osecpu_dr_capture #(.DW(32), .NCH(3), .DEPTH(8), .MODE(0)) u_n3 (
      .clk(clk), .reset(rst_n), .cap_valid(cap_valid), .cap_ch(cap_ch), .cap_data(cap_data),
      .clr(clr), .dr_flat(dr3), .stall(st3), .out_valid(ov3), .out_ready(out_ready),
      .out_ch(oc3), .out_data(od3), .count(cn3), .ovf_cnt(of3), .bad_ch(bd3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] data;
      logic [3:0]  cnt0;
      logic [15:0] ovf0;
      logic [3:0]  cnt1;
      logic [15:0] ovf1;
      logic        stall2;
   } fill_t;

   fill_t tbl [10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cap_valid = 1'b0;
      out_ready = 1'b0;
      clr       = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n     = 1'b1;
   endtask

   task automatic capture(input logic [1:0] ch, input logic [31:0] d);
      cap_valid = 1'b1;
      cap_ch    = ch;
      cap_data  = d;
      tick();
      cap_valid = 1'b0;
   endtask

   task automatic test_one(input string tag);
      capture(2'd2, 32'hDEADBEEF);
      chk({tag, " dr_flat"}, dr0, {32'h0, 32'hDEADBEEF, 64'h0});
      chk({tag, " out_valid"}, 128'(ov0), 128'd1);
      chk({tag, " out_ch"}, 128'(oc0), 128'd2);
      chk({tag, " out_data"}, 128'(od0), 128'hDEADBEEF);
      chk({tag, " count"}, 128'(cn0), 128'd1);
   endtask

   initial begin
      tbl[0] = '{2'd3, 32'd1,  4'd1, 16'd0, 4'd1, 16'd0, 1'b0};
      tbl[1] = '{2'd3, 32'd2,  4'd2, 16'd0, 4'd2, 16'd0, 1'b0};
      tbl[2] = '{2'd3, 32'd3,  4'd3, 16'd0, 4'd3, 16'd0, 1'b0};
      tbl[3] = '{2'd3, 32'd4,  4'd4, 16'd0, 4'd4, 16'd0, 1'b0};
      tbl[4] = '{2'd3, 32'd5,  4'd5, 16'd0, 4'd5, 16'd0, 1'b0};
      tbl[5] = '{2'd3, 32'd6,  4'd6, 16'd0, 4'd6, 16'd0, 1'b0};
      tbl[6] = '{2'd3, 32'd7,  4'd7, 16'd0, 4'd7, 16'd0, 1'b0};
      tbl[7] = '{2'd3, 32'd8,  4'd8, 16'd0, 4'd8, 16'd0, 1'b1};
      tbl[8] = '{2'd3, 32'd9,  4'd8, 16'd1, 4'd8, 16'd1, 1'b1};
      tbl[9] = '{2'd3, 32'd10, 4'd8, 16'd2, 4'd8, 16'd2, 1'b1};

      cap_ch   = 2'd0;
      cap_data = 32'd0;
      do_reset();

      // Reset state
      chk("rst count", 128'(cn0), 128'd0);
      chk("rst out_valid", 128'(ov0), 128'd0);
      chk("rst dr_flat", dr0, 128'd0);
      chk("rst ovf_cnt", 128'(of0), 128'd0);
      chk("rst bad_ch", 128'(bd0), 128'd0);
      chk("rst stall m2", 128'(st2), 128'd0);

      // Single capture
      test_one("t1");

      // Fill past full: MODE 0 drops, MODE 1 overwrites, MODE 2 stalls
      do_reset();
      for (int i = 0; i < 10; i++) begin
         capture(tbl[i].ch, tbl[i].data);
         chk($sformatf("fill%0d m0 count", i), 128'(cn0), 128'(tbl[i].cnt0));
         chk($sformatf("fill%0d m0 ovf", i), 128'(of0), 128'(tbl[i].ovf0));
         chk($sformatf("fill%0d m1 count", i), 128'(cn1), 128'(tbl[i].cnt1));
         chk($sformatf("fill%0d m1 ovf", i), 128'(of1), 128'(tbl[i].ovf1));
         chk($sformatf("fill%0d m2 stall", i), 128'(st2), 128'(tbl[i].stall2));
      end
      chk("t2 latest ch3", dr0[127:96], 128'd10);
      chk("t2 m0 stall const", 128'(st0), 128'd0);
      chk("t4 m2 ovf", 128'(of2), 128'd2);

      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d m0 data", k), 128'(od0), 128'(k + 1));
         chk($sformatf("drain%0d m1 data", k), 128'(od1), 128'(k + 3));
         chk($sformatf("drain%0d m2 data", k), 128'(od2), 128'(k + 1));
         tick();
         if (k == 0) begin
            chk("t4 pop count", 128'(cn2), 128'd7);
            chk("t4 pop stall", 128'(st2), 128'd0);
         end
      end
      out_ready = 1'b0;
      chk("drain m0 empty", 128'(ov0), 128'd0);
      chk("drain m1 count", 128'(cn1), 128'd0);

      // MODE 2: push and pop while full
      do_reset();
      for (int i = 1; i <= 8; i++) capture(2'd1, 32'h100 + 32'(i));
      chk("t4 full stall", 128'(st2), 128'd1);
      chk("t4 full count", 128'(cn2), 128'd8);
      chk("t4 head before", 128'(od2), 128'h101);
      out_ready = 1'b1;
      capture(2'd1, 32'h109);
      out_ready = 1'b0;
      chk("t4 pp count", 128'(cn2), 128'd8);
      chk("t4 pp stall", 128'(st2), 128'd1);
      chk("t4 pp ovf", 128'(of2), 128'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t4 drain%0d", k), 128'(od2), 128'h102 + 128'(k));
         chk($sformatf("t4 drain%0d ch", k), 128'(oc2), 128'd1);
         tick();
      end
      out_ready = 1'b0;
      chk("t4 empty", 128'(cn2), 128'd0);

      // Bad channel on NCH=3, then clr
      do_reset();
      for (int i = 1; i <= 10; i++) capture(2'd1, 32'h100 + 32'(i));
      chk("t5 pre count", 128'(cn3), 128'd8);
      chk("t5 pre ovf", 128'(of3), 128'd2);
      capture(2'd3, 32'h99);
      chk("t5 bad_ch", 128'(bd3), 128'd1);
      chk("t5 count kept", 128'(cn3), 128'd8);
      chk("t5 ovf kept", 128'(of3), 128'd2);
      chk("t5 dr kept", 128'(dr3), {32'h0, 32'h0, 32'h10A, 32'h0});
      chk("t5 pow2 no bad", 128'(bd0), 128'd0);
      chk("t5 m0 ovf", 128'(of0), 128'd3);
      clr = 1'b1;
      capture(2'd0, 32'h77);
      clr = 1'b0;
      chk("t5 clr bad_ch", 128'(bd3), 128'd0);
      chk("t5 clr count", 128'(cn3), 128'd0);
      chk("t5 clr out_valid", 128'(ov3), 128'd0);
      chk("t5 clr ovf", 128'(of3), 128'd0);
      chk("t5 clr dr", 128'(dr3), {32'h0, 32'h0, 32'h10A, 32'h77});
      chk("t5 m0 clr ovf", 128'(of0), 128'd0);

      // Asynchronous reset mid-drain
      do_reset();
      for (int i = 0; i < 5; i++) capture(2'd0, 32'hA0 + 32'(i));
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      chk("t6 mid count", 128'(cn0), 128'd3);
      chk("t6 mid head", 128'(od0), 128'hA2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6 async count", 128'(cn0), 128'd0);
      chk("t6 async out_valid", 128'(ov0), 128'd0);
      chk("t6 async dr_flat", dr0, 128'd0);
      tick();
      rst_n = 1'b1;
      test_one("t6 after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
